// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with valid/ready load and first/last framing.
// Optional even-parity trailer bit when PISO_TX_PARITY_EN is defined.
module piso_tx #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] I,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last,
  output logic             busy
);

  localparam int unsigned CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;
  logic             cnt_last;
  logic             head;
  logic             accept;
`ifdef PISO_TX_PARITY_EN
  logic             parity_q;
`endif

  assign cnt_last = (cnt_q == LAST_CNT);
  assign head     = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign accept   = load_valid && load_ready;

  // State register
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a frame's final cycle can chain straight into the next word
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_DATA;
      S_DATA: begin
        if (cnt_last) begin
`ifdef PISO_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = accept ? S_DATA : S_IDLE;
`endif
        end
      end
`ifdef PISO_TX_PARITY_EN
      S_PARITY: state_d = accept ? S_DATA : S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state only
  always_comb begin
    load_ready = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    sout_first = 1'b0;
    sout_last  = 1'b0;
    busy       = 1'b0;
    case (state_q)
      S_IDLE: load_ready = 1'b1;
      S_DATA: begin
        sout       = head;
        sout_valid = 1'b1;
        busy       = 1'b1;
        sout_first = (cnt_q == '0);
`ifndef PISO_TX_PARITY_EN
        if (cnt_last) begin
          sout_last  = 1'b1;
          load_ready = 1'b1;
        end
`endif
      end
`ifdef PISO_TX_PARITY_EN
      S_PARITY: begin
        sout       = parity_q;
        sout_valid = 1'b1;
        sout_last  = 1'b1;
        busy       = 1'b1;
        load_ready = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Shift register, bit counter and captured parity
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      shreg_q  <= '0;
      cnt_q    <= '0;
`ifdef PISO_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (accept) begin
      shreg_q  <= I;
      cnt_q    <= '0;
`ifdef PISO_TX_PARITY_EN
      parity_q <= ^I;
`endif
    end else if (state_q == S_DATA) begin
      shreg_q <= MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
      if (!cnt_last) cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first and LSB-first instances checked against a frame-queue model.
module tb_piso_tx;

  localparam int unsigned W = 4;
`ifdef PISO_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int unsigned N = W + (PAR ? 1 : 0);

  logic         clk = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] I = '0;
  logic         load_valid = 1'b0;

  logic rdy_m, so_m, sv_m, sf_m, sl_m, bz_m;
  logic rdy_l, so_l, sv_l, sf_l, sl_l, bz_l;
  logic [5:0] act_m, act_l;
  assign act_m = {rdy_m, so_m, sv_m, sf_m, sl_m, bz_m};
  assign act_l = {rdy_l, so_l, sv_l, sf_l, sl_l, bz_l};

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .clear(clear), .I(I), .load_valid(load_valid), .load_ready(rdy_m),
    .sout(so_m), .sout_valid(sv_m), .sout_first(sf_m), .sout_last(sl_m), .busy(bz_m));

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .clear(clear), .I(I), .load_valid(load_valid), .load_ready(rdy_l),
    .sout(so_l), .sout_valid(sv_l), .sout_first(sf_l), .sout_last(sl_l), .busy(bz_l));

  // Model: queue of bits still to be shown; the head is the bit on the wire this cycle
  typedef struct packed {logic b; logic f; logic l;} fbit_t;
  fbit_t qm[$];
  fbit_t ql[$];

  task automatic push_frame(input logic [W-1:0] w);
    fbit_t fm, fl;
    for (int k = 0; k < int'(W); k++) begin
      fm.b = w[W-1-k];
      fl.b = w[k];
      fm.f = (k == 0);
      fl.f = (k == 0);
      fm.l = (!PAR && k == int'(W) - 1);
      fl.l = fm.l;
      qm.push_back(fm);
      ql.push_back(fl);
    end
    if (PAR) begin
      fm.b = ^w; fm.f = 1'b0; fm.l = 1'b1;
      qm.push_back(fm);
      ql.push_back(fm);
    end
  endtask

  // {load_ready, sout, sout_valid, sout_first, sout_last, busy}
  function automatic logic [5:0] exp_vec(input bit msb);
    fbit_t f;
    int    sz;
    sz = msb ? qm.size() : ql.size();
    if (sz == 0) return 6'b100000;
    f = msb ? qm[0] : ql[0];
    return {(sz <= 1), f.b, 1'b1, f.f, f.l, 1'b1};
  endfunction

  // Advance one clock edge in DUT and model, return 1 ns after the edge
  task automatic tick();
    bit acc;
    @(posedge clk);
    if (!clear) begin
      qm.delete();
      ql.delete();
    end else begin
      acc = load_valid && (qm.size() <= 1);
      if (qm.size() != 0) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (acc) push_frame(I);
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      I = W'($urandom);
      load_valid = 1'($urandom);
      tick();
      compared++;
      if ({act_m, act_l} !== {6'b100000, 6'b100000}) begin
        mismatched++;
        $display("FAIL reset cyc=%0d got=%b_%b exp=100000_100000", cyc, act_m, act_l);
      end
    end
    load_valid = 1'b0;
    clear = 1'b1;
  endtask

  task automatic test_single();
    logic [N-1:0] seq_m, seq_l, want_m, want_l;
    seq_m = '0; seq_l = '0;
`ifdef PISO_TX_PARITY_EN
    want_m = 5'b10111; want_l = 5'b11011;
`else
    want_m = 4'b1011;  want_l = 4'b1101;
`endif
    I = 4'b1011;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    I = W'($urandom);
    for (int c = 1; c <= int'(N) + 2; c++) begin
      compared++;
      if ({act_m, act_l} !== {exp_vec(1), exp_vec(0)}) begin
        mismatched++;
        $display("FAIL single cyc=%0d got=%b_%b exp=%b_%b", c, act_m, act_l, exp_vec(1), exp_vec(0));
      end
      if (c <= int'(N)) begin
        seq_m = {seq_m[N-2:0], so_m};
        seq_l = {seq_l[N-2:0], so_l};
      end
      tick();
    end
    compared++;
    if ({seq_m, seq_l} !== {want_m, want_l}) begin
      mismatched++;
      $display("FAIL single_seq got=%b_%b exp=%b_%b", seq_m, seq_l, want_m, want_l);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*N-1:0] seq_m, want_m;
    int vcount;
    seq_m = '0; vcount = 0;
    want_m = {N'(4'b1111) << (N - W), N'(0)};
    I = 4'b1111;
    load_valid = 1'b1;
    tick();
    I = 4'b0000;
    for (int c = 1; c <= 2 * int'(N) + 2; c++) begin
      compared++;
      if ({act_m, act_l} !== {exp_vec(1), exp_vec(0)}) begin
        mismatched++;
        $display("FAIL b2b cyc=%0d got=%b_%b exp=%b_%b", c, act_m, act_l, exp_vec(1), exp_vec(0));
      end
      if (c <= 2 * int'(N)) begin
        seq_m = {seq_m[2*N-2:0], so_m};
        if (sv_m && sv_l) vcount++;
      end
      if (c == int'(N)) begin
        compared++;
        if (rdy_m !== 1'b1) begin
          mismatched++;
          $display("FAIL b2b_ready cyc=%0d got=%b exp=1", c, rdy_m);
        end
      end
      tick();
      if (c == int'(N)) load_valid = 1'b0;
    end
    compared++;
    if (seq_m !== want_m || vcount != 2 * int'(N)) begin
      mismatched++;
      $display("FAIL b2b_seq got=%b valid_run=%0d exp=%b valid_run=%0d", seq_m, vcount, want_m, 2 * N);
    end
  endtask

  task automatic test_busy_ignore();
    int extra;
    extra = 0;
    I = 4'b1011;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int c = 1; c <= int'(N) + 4; c++) begin
      compared++;
      if ({act_m, act_l} !== {exp_vec(1), exp_vec(0)}) begin
        mismatched++;
        $display("FAIL busy_ignore cyc=%0d got=%b_%b exp=%b_%b", c, act_m, act_l, exp_vec(1), exp_vec(0));
      end
      if (c > int'(N) && (sv_m || sv_l)) extra++;
      I = W'($urandom);
      load_valid = (c == 1 || c == 2);
      tick();
    end
    load_valid = 1'b0;
    compared++;
    if (extra != 0) begin
      mismatched++;
      $display("FAIL busy_extra_frame got=%0d valid cycles exp=0", extra);
    end
  endtask

  task automatic test_mid_reset();
    logic [N-1:0] seq_m, seq_l, want;
    seq_m = '0; seq_l = '0;
    want = N'(4'b0110) << (N - W);
    I = W'($urandom);
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    #2 clear = 1'b0;
    #1;
    qm.delete();
    ql.delete();
    compared++;
    if ({act_m, act_l} !== {6'b100000, 6'b100000}) begin
      mismatched++;
      $display("FAIL async_reset got=%b_%b exp=100000_100000", act_m, act_l);
    end
    tick();
    compared++;
    if ({act_m, act_l} !== {6'b100000, 6'b100000}) begin
      mismatched++;
      $display("FAIL reset_hold got=%b_%b exp=100000_100000", act_m, act_l);
    end
    clear = 1'b1;
    I = 4'b0110;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int c = 1; c <= int'(N) + 1; c++) begin
      compared++;
      if ({act_m, act_l} !== {exp_vec(1), exp_vec(0)}) begin
        mismatched++;
        $display("FAIL post_reset cyc=%0d got=%b_%b exp=%b_%b", c, act_m, act_l, exp_vec(1), exp_vec(0));
      end
      if (c <= int'(N)) begin
        seq_m = {seq_m[N-2:0], so_m};
        seq_l = {seq_l[N-2:0], so_l};
      end
      tick();
    end
    compared++;
    if ({seq_m, seq_l} !== {want, want}) begin
      mismatched++;
      $display("FAIL post_reset_seq got=%b_%b exp=%b_%b", seq_m, seq_l, want, want);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      I = W'($urandom);
      load_valid = ($urandom_range(0, 3) != 0);
      tick();
      compared++;
      if ({act_m, act_l} !== {exp_vec(1), exp_vec(0)}) begin
        mismatched++;
        $display("FAIL random cyc=%0d got=%b_%b exp=%b_%b", c, act_m, act_l, exp_vec(1), exp_vec(0));
      end
    end
    load_valid = 1'b0;
    for (int c = 0; c < int'(N) + 1; c++) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_ignore();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
